// File: rtl/mul.sv
// mul: free-running sequential shift-add multiplier.
//   Every 10 clock cycles: one LOAD edge captures the operands, eight CALC
//   edges shift-add into a 2*WIDTH accumulator, and one DONE edge
//   publishes the result with a one-cycle done pulse.
// Ports:
//   clock        - single clock, rising edge
//   reset        - asynchronous active-high reset
//   multiplier   - unsigned operand A, sampled only on the LOAD edge
//   multiplicand - unsigned operand B, sampled only on the LOAD edge
//   result       - registered low WIDTH bits of A*B (saturated, see below)
//   done         - one-cycle pulse after each result update
//   overflow     - registered flag, product does not fit in WIDTH bits
// Config macro:
//   MUL_SATURATE_EN - when defined, result is all-ones on overflow instead
//                     of wrapping; overflow behaves the same either way.
module mul #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] multiplier,
  input  logic [WIDTH-1:0] multiplicand,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {LOAD, CALC, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic               last;
  logic               ovf_nxt;
  logic [WIDTH-1:0]   res_nxt;

  // cnt still holds the pre-increment value on the final CALC edge
  assign last    = (cnt == CW'(WIDTH - 1));
  assign ovf_nxt = |acc[2*WIDTH-1:WIDTH];

`ifdef MUL_SATURATE_EN
  assign res_nxt = ovf_nxt ? '1 : acc[WIDTH-1:0];
`else
  assign res_nxt = acc[WIDTH-1:0];
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= LOAD;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    state_nxt = CALC;
      CALC:    if (last) state_nxt = DONE;
      DONE:    state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mplier   <= '0;
      mcand    <= '0;
      acc      <= '0;
      cnt      <= '0;
      result   <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        LOAD: begin
          mplier <= multiplier;
          mcand  <= {{WIDTH{1'b0}}, multiplicand};
          acc    <= '0;
          cnt    <= '0;
        end
        CALC: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
        end
        DONE: begin
          result   <= res_nxt;
          overflow <= ovf_nxt;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul.sv
// tb_mul: self-checking bench for mul (WIDTH=8). Directed scenarios plus a
// randomized run against an arithmetic reference model. All driving and
// sampling happens on the falling clock edge.
module tb_mul;

  logic       clock;
  logic       reset;
  logic [7:0] multiplier;
  logic [7:0] multiplicand;
  logic [7:0] result;
  logic       done;
  logic       overflow;

  int compared   = 0;
  int mismatched = 0;

  mul #(.WIDTH(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .multiplier   (multiplier),
    .multiplicand (multiplicand),
    .result       (result),
    .done         (done),
    .overflow     (overflow)
  );

  initial clock = 1'b0;
  always #100 clock = ~clock;

  // Reference: {overflow, result} from plain integer multiplication.
  function automatic logic [8:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    int  p;
    logic ovf;
    logic [7:0] r;
    p   = int'(a) * int'(b);
    ovf = (p > 255);
    r   = 8'(p % 256);
`ifdef MUL_SATURATE_EN
    if (ovf) r = 8'hFF;
`endif
    return {ovf, r};
  endfunction

  // Advance n rising edges, ending on the following falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Reset, then release on a falling edge: the next rising edge is edge 1.
  task automatic do_reset(input logic [7:0] a, input logic [7:0] b);
    multiplier   = a;
    multiplicand = b;
    reset        = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    multiplier = 8'd0; multiplicand = 8'd0;
    reset = 1'b0;
    tick(1);
    #20 reset = 1'b1;
    #1;
    compared++;
    if (result !== 8'h00 || done !== 1'b0 || overflow !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_outputs: got result=%h done=%b ovf=%b, want 00 0 0", result, done, overflow);
    end
    tick(1);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    do_reset(8'd7, 8'd8);
    for (int e = 1; e <= 9; e++) begin
      tick(1);
      compared++;
      if (done !== 1'b0 || result !== 8'h00) begin
        mismatched++;
        $display("FAIL basic_pre_done edge %0d: got done=%b result=%h, want 0 00", e, done, result);
      end
    end
    tick(1);
    compared++;
    if (result !== 8'h38 || done !== 1'b1 || overflow !== 1'b0) begin
      mismatched++;
      $display("FAIL basic_edge10: got result=%h done=%b ovf=%b, want 38 1 0", result, done, overflow);
    end
    tick(1);
    compared++;
    if (done !== 1'b0 || result !== 8'h38) begin
      mismatched++;
      $display("FAIL basic_edge11: got done=%b result=%h, want 0 38", done, result);
    end
    tick(9);
    compared++;
    if (result !== 8'h38 || done !== 1'b1) begin
      mismatched++;
      $display("FAIL basic_edge20: got result=%h done=%b, want 38 1", result, done);
    end
  endtask

  task automatic test_zero();
    do_reset(8'd0, 8'hAB);
    tick(10);
    compared++;
    if (result !== 8'h00 || overflow !== 1'b0 || done !== 1'b1) begin
      mismatched++;
      $display("FAIL zero_operand: got result=%h ovf=%b done=%b, want 00 0 1", result, overflow, done);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp256, exp_ff;
`ifdef MUL_SATURATE_EN
    exp256 = 8'hFF; exp_ff = 8'hFF;
`else
    exp256 = 8'h00; exp_ff = 8'h01;
`endif
    do_reset(8'd16, 8'd16);
    tick(10);
    compared++;
    if (result !== exp256 || overflow !== 1'b1 || done !== 1'b1) begin
      mismatched++;
      $display("FAIL ovf_16x16: got result=%h ovf=%b done=%b, want %h 1 1", result, overflow, done, exp256);
    end
    do_reset(8'd255, 8'd255);
    tick(10);
    compared++;
    if (result !== exp_ff || overflow !== 1'b1 || done !== 1'b1) begin
      mismatched++;
      $display("FAIL ovf_255x255: got result=%h ovf=%b done=%b, want %h 1 1", result, overflow, done, exp_ff);
    end
  endtask

  task automatic test_operand_change();
    do_reset(8'd7, 8'd8);
    tick(5);
    multiplier = 8'd3; multiplicand = 8'd5;
    tick(5);
    compared++;
    if (result !== 8'd56 || done !== 1'b1) begin
      mismatched++;
      $display("FAIL opchg_edge10: got result=%0d done=%b, want 56 1", result, done);
    end
    tick(10);
    compared++;
    if (result !== 8'd15 || done !== 1'b1) begin
      mismatched++;
      $display("FAIL opchg_edge20: got result=%0d done=%b, want 15 1", result, done);
    end
  endtask

  task automatic test_mid_reset();
    do_reset(8'd9, 8'd9);
    tick(10);
    compared++;
    if (result !== 8'd81) begin
      mismatched++;
      $display("FAIL midrst_first: got result=%0d, want 81", result);
    end
    multiplier = 8'd20; multiplicand = 8'd20;
    tick(6);
    multiplier = 8'd9; multiplicand = 8'd9;
    reset = 1'b1;
    #1;
    compared++;
    if (result !== 8'h00 || done !== 1'b0 || overflow !== 1'b0) begin
      mismatched++;
      $display("FAIL midrst_abort: got result=%h done=%b ovf=%b, want 00 0 0", result, done, overflow);
    end
    tick(1);
    reset = 1'b0;
    tick(10);
    compared++;
    if (result !== 8'd81 || done !== 1'b1 || overflow !== 1'b0) begin
      mismatched++;
      $display("FAIL midrst_after: got result=%0d done=%b ovf=%b, want 81 1 0", result, done, overflow);
    end
  endtask

  // Back-to-back random products; operands are scrambled between LOAD
  // edges and must have no effect on the running computation.
  task automatic test_random();
    logic [7:0] a, b, prev_r;
    logic       prev_o;
    logic [8:0] exp;
    do_reset(8'd0, 8'd0);
    prev_r = 8'h00; prev_o = 1'b0;
    for (int k = 0; k < 12; k++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      if (k == 0) a = 8'd1;
      multiplier = a; multiplicand = b;
      exp = ref_mul(a, b);
      for (int c = 1; c <= 9; c++) begin
        tick(1);
        compared++;
        if (done !== 1'b0 || result !== prev_r || overflow !== prev_o) begin
          mismatched++;
          $display("FAIL rand_hold k=%0d c=%0d: got done=%b result=%h ovf=%b, want 0 %h %b",
                   k, c, done, result, overflow, prev_r, prev_o);
        end
        multiplier   = 8'($urandom);
        multiplicand = 8'($urandom);
      end
      tick(1);
      compared++;
      if (done !== 1'b1 || result !== exp[7:0] || overflow !== exp[8]) begin
        mismatched++;
        $display("FAIL rand_done k=%0d %0d*%0d: got done=%b result=%h ovf=%b, want 1 %h %b",
                 k, a, b, done, result, overflow, exp[7:0], exp[8]);
      end
      prev_r = exp[7:0];
      prev_o = exp[8];
    end
  endtask

  initial begin
    reset = 1'b1;
    multiplier = 8'd0;
    multiplicand = 8'd0;
    test_reset();
    test_basic();
    test_zero();
    test_overflow();
    test_operand_change();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
